// File: rtl/signed_multiplier_seq.sv
// Sequential two's-complement multiplier (shift-and-add over N cycles).
// Operand magnitudes come from `negative` stages keyed on the sign bits;
// the magnitude product is re-signed by a second `negative` stage.

// Conditional two's-complement negation: y = en ? -x : x.
module negative #(
    parameter int W = 8
) (
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    // Pure combinational negate; -0 == 0, and -(100..0) stays 100..0,
    // which is the correct unsigned magnitude for the most negative value.
    always_comb begin
        y_o = en_i ? (~x_i + {{(W-1){1'b0}}, 1'b1}) : x_i;
    end
endmodule

module signed_multiplier_seq #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic             sgn_q, sgn_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     a_mag, b_mag;
    logic [2*N-1:0]   prod_signed;
    logic [N:0]       psum;

    negative #(.W(N)) u_neg_a (
        .en_i (a[N-1]),
        .x_i  (a),
        .y_o  (a_mag)
    );

    negative #(.W(N)) u_neg_b (
        .en_i (b[N-1]),
        .x_i  (b),
        .y_o  (b_mag)
    );

    negative #(.W(2*N)) u_neg_p (
        .en_i (sgn_q),
        .x_i  (acc_q),
        .y_o  (prod_signed)
    );

    // Partial sum keeps the carry so the right shift can pull it into acc.
    always_comb begin
        psum = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    end

    // Next-state and datapath control; start is only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    sgn_d    = a[N-1] ^ b[N-1];
                    acc_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = {psum, acc_q[N-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_q == CW'(N-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                product_d = prod_signed;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation and clears the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sgn_q     <= 1'b0;
            acc_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sgn_q     <= sgn_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: doc/signed_multiplier_seq.md
Name: signed_multiplier_seq

Overview:
- Sequential signed multiplier for two's-complement operands using shift-and-add.
- Feeds each operand through a `negative` stage (enable = operand sign bit) to get unsigned magnitudes.
- Multiplies the magnitudes over N iterations, then feeds the 2N-bit magnitude product through a second `negative` stage (enable = result sign) to restore the sign.
- Sits in the datapath beside the register file as the multi-cycle MUL unit.

Parameters:
N, 64, operand width in bits; product width is 2N.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only when not busy
a  input  N  multiplicand, two's complement
b  input  N  multiplier, two's complement
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; product valid from this cycle
product  output  2N  signed result a*b, two's complement

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time): state=IDLE, busy=0, done=0, product=0, all internal registers=0.
  - Reset mid-operation aborts the operation; no done pulse; product reads 0.
- FSM states: IDLE, CALC, FIX.
- IDLE: on a rising edge with start=1:
  - mcand <= |a| (N-bit unsigned), mplier <= |b|, sgn <= a[N-1]^b[N-1].
  - acc(2N) <= 0, count <= 0, busy <= 1, next state CALC.
  - start=0: remain in IDLE; product holds its last value.
- Magnitudes are unsigned N-bit values. -2^(N-1) gives magnitude 2^(N-1) (pattern 100..0), which is correct as unsigned; no overflow handling needed.
- CALC: exactly N cycles, one bit per cycle.
  - Partial sum: upper half of acc plus (mplier LSB ? mcand : 0), computed N+1 bits wide (carry kept).
  - {carry, acc} shifts right by 1 using the partial sum as the new upper half; mplier shifts right by 1; count increments.
  - The edge where count reaches N-1 moves to FIX.
- FIX: one cycle.
  - product <= sgn ? -acc : acc (2N-bit two's-complement negation).
  - done <= 1, busy <= 0, next state IDLE.
- Latency: start sampled at edge k; done=1 and product valid after edge k+N+1, i.e. N+1 cycles. Throughput: one operation per N+1 cycles.
- done is high for exactly one cycle. product stays stable until the next FIX or reset.
- start while busy=1: ignored; operands are not re-sampled and the running operation is unaffected.
- start in the done cycle: accepted, because the FSM is already in IDLE (back-to-back operation).
- a and b may change freely after the sampling edge; the result depends only on the sampled values.
- Result range: every product fits in 2N signed bits, including (-2^(N-1))^2 = 2^(2N-2). No overflow flag.
- Zero: a zero operand yields product=0 regardless of sign (negating 0 gives 0).

Test Plan (N=8 instance unless stated):
- a=7, b=-3 (0xFD), start pulse -> exactly 9 cycles later done=1 for 1 cycle; product=0xFFEB (-21); busy high for the 9 cycles in between.
- a=-128 (0x80), b=-128 -> product=0x4000. Then a=-128, b=127 -> product=0xC080 (-16256). Then a=0, b=-5 -> product=0x0000.
- Start a=5, b=6; at cycle 3 assert start with a=-1, b=-1 -> ignored; product=0x001E (30); only one done pulse.
- Assert start with a=-2, b=3 in the same cycle done rises for a prior 4*4 op -> first product=0x0010, second done 9 cycles later with product=0xFFFA (-6).
- Drive rst_n low asynchronously mid-CALC (cycle 4) -> busy, done and product go to 0 immediately; no done pulse after release; a new start then completes normally.
- N=64 instance: a=0x7FFF_FFFF_FFFF_FFFF, b=-1 -> done 65 cycles after start; product=0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001.
